// File: rtl/seq_shift_pkg.sv
// Shared constants for the iterative shift unit: the 2-bit shift mode field
// (same encoding as the single-cycle shifter) and the control FSM states.
package seq_shift_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step_1b.sv
// Combinational single-bit shift step. Given the working word and the mode,
// produces the word after one bit position of shifting and the bit that
// falls off the end.
module shift_step_1b
    import seq_shift_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] word,
    input  logic [1:0]   mode,
    output logic [W-1:0] next_word,
    output logic         out_bit
);

    // Upper W-1 bits moved down one place; shared by all right-going modes.
    logic [W-2:0] rsh_body;

    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_rsh
            assign rsh_body[gi] = word[gi+1];
        end
    endgenerate

    // Select the fill bit on the vacated end and the bit shifted out.
    always_comb begin
        next_word = {word[W-2:0], 1'b0};
        out_bit   = word[W-1];
        case (mode)
            MODE_LSR: begin
                next_word = {1'b0, rsh_body};
                out_bit   = word[0];
            end
            MODE_ASR: begin
                next_word = {word[W-1], rsh_body};
                out_bit   = word[0];
            end
            MODE_ROR: begin
                next_word = {word[0], rsh_body};
                out_bit   = word[0];
            end
            default: begin
                next_word = {word[W-2:0], 1'b0};
                out_bit   = word[W-1];
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shift engine: LSL/LSR/ASR/ROR by a variable amount, one bit per
// clock, with a valid/ready start handshake and a one-cycle result strobe.
// A new request may be accepted in the DONE cycle, so back-to-back
// operations run without an idle gap.
// Build option: define SEQ_SHIFT_CARRY_EN to add i_carry_in / o_carry and
// track the last bit shifted out; without it the carry logic is absent.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter  int W  = 32,
    localparam int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [1:0]    i_mode,
    input  logic [SW-1:0] i_amount,
    input  logic [W-1:0]  i_data,
    output logic          o_valid,
    output logic [W-1:0]  o_data
`ifdef SEQ_SHIFT_CARRY_EN
    ,
    input  logic          i_carry_in,
    output logic          o_carry
`endif
);

    state_t        state_reg, state_next;
    logic [SW-1:0] count_reg;
    logic [W-1:0]  work_reg;
    logic [1:0]    mode_reg;
    logic [W-1:0]  data_out_reg;
    logic [W-1:0]  step_word;
    logic          accept;
    logic          last_step;

`ifdef SEQ_SHIFT_CARRY_EN
    logic          carry_out_reg;
    logic          step_bit;
`else
    logic          step_bit_unused;
`endif

    assign o_ready   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign o_valid   = (state_reg == ST_DONE);
    assign o_data    = data_out_reg;
    assign accept    = i_valid && o_ready;
    assign last_step = (count_reg == SW'(1));

`ifdef SEQ_SHIFT_CARRY_EN
    assign o_carry = carry_out_reg;
`endif

    shift_step_1b #(
        .W (W)
    ) u_step (
        .word      (work_reg),
        .mode      (mode_reg),
        .next_word (step_word),
`ifdef SEQ_SHIFT_CARRY_EN
        .out_bit   (step_bit)
`else
        .out_bit   (step_bit_unused)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a zero-distance request goes straight to DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (i_amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = (i_amount != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Working word, counter and result registers; results load only on the
    // transition into DONE so o_data holds between operations.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg    <= '0;
            work_reg     <= '0;
            mode_reg     <= MODE_LSL;
            data_out_reg <= '0;
        end else if (accept) begin
            work_reg  <= i_data;
            mode_reg  <= i_mode;
            count_reg <= i_amount;
            if (i_amount == '0) begin
                data_out_reg <= i_data;
            end
        end else if (state_reg == ST_SHIFT) begin
            work_reg  <= step_word;
            count_reg <= count_reg - SW'(1);
            if (last_step) begin
                data_out_reg <= step_word;
            end
        end
    end

`ifdef SEQ_SHIFT_CARRY_EN
    // Carry result: incoming carry for a zero shift, else the final bit out.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            carry_out_reg <= 1'b0;
        end else if (accept) begin
            if (i_amount == '0) begin
                carry_out_reg <= i_carry_in;
            end
        end else if ((state_reg == ST_SHIFT) && last_step) begin
            carry_out_reg <= step_bit;
        end
    end
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (W=32). Expected results come from a
// closed-form shift model and are queued when a request is accepted; the
// monitor pops and compares on every o_valid, including the result cycle.
module tb_seq_shift_unit;

    localparam int W  = 32;
    localparam int SW = $clog2(W);

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_mode;
    logic [SW-1:0] i_amount;
    logic [W-1:0]  i_data;
    logic          i_carry_in;
    logic          o_valid;
    logic [W-1:0]  o_data;
`ifdef SEQ_SHIFT_CARRY_EN
    logic          o_carry;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    seq_shift_unit #(
        .W (W)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mode     (i_mode),
        .i_amount   (i_amount),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_data     (o_data)
`ifdef SEQ_SHIFT_CARRY_EN
        ,
        .i_carry_in (i_carry_in),
        .o_carry    (o_carry)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Closed-form reference: {carry, data}.
    function automatic logic [W:0] model(input logic [1:0] mode, input int n,
                                         input logic [W-1:0] d, input logic cin);
        logic signed [W-1:0] sd;
        logic [W-1:0] r;
        logic c;
        if (n == 0) return {cin, d};
        sd = d;
        case (mode)
            2'b00: begin r = d << n; c = d[W-n]; end
            2'b01: begin r = d >> n; c = d[n-1]; end
            2'b10: begin r = sd >>> n; c = d[n-1]; end
            default: begin r = (d >> n) | (d << (W - n)); c = d[n-1]; end
        endcase
        return {c, r};
    endfunction

    // Result monitor: every strobe must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result cyc=%0d data=0x%08h exp=0x%08h", cyc, o_data, e.data);
                check_val("data", 64'(o_data), 64'(e.data));
                check_val("latency", 64'(cyc), 64'(e.cyc));
`ifdef SEQ_SHIFT_CARRY_EN
                check_val("carry", 64'(o_carry), 64'(e.carry));
`endif
            end
        end
    end

    // Called at a negedge; drives a request, waits for acceptance, returns at
    // the negedge after the accepting edge with i_valid low.
    task automatic send(input logic [1:0] mode, input int amt, input logic [W-1:0] d, input logic cin);
        exp_t e;
        logic [W:0] m;
        int budget;
        i_valid    = 1'b1;
        i_mode     = mode;
        i_amount   = SW'(amt);
        i_data     = d;
        i_carry_in = cin;
        budget     = 100;
        while (!o_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!o_ready) begin
            check_val("accept_timeout", 64'(o_ready), 64'd1);
        end else begin
            m = model(mode, amt, d, cin);
            e.data  = m[W-1:0];
            e.carry = m[W];
            e.cyc   = cyc + 1 + amt;
            sb.push_back(e);
            $display("send mode=%0d amt=%0d data=0x%08h", mode, amt, d);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        cyc        = 0;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_mode     = 2'b00;
        i_amount   = '0;
        i_data     = '0;
        i_carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'(o_ready), 64'd1);
        check_val("rst_valid", 64'(o_valid), 64'd0);
        check_val("rst_data", 64'(o_data), 64'd0);
`ifdef SEQ_SHIFT_CARRY_EN
        check_val("rst_carry", 64'(o_carry), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        send(2'b00, 3, 32'h0000_0005, 1'b0); drain();
        send(2'b10, 31, 32'h8000_0000, 1'b0); drain();
        send(2'b11, 1, 32'h0000_0003, 1'b0); drain();
        send(2'b01, 4, 32'h8000_0000, 1'b1); drain();
        send(2'b01, 0, 32'h1234_5678, 1'b1); drain();
        send(2'b01, 0, 32'h8765_4321, 1'b0); drain();

        // Back-to-back with no gap: request accepted in the DONE cycle.
        send(2'b00, 2, 32'hA5A5_0F0F, 1'b0);
        send(2'b11, 1, 32'h0000_0001, 1'b0);
        send(2'b10, 0, 32'hC000_0000, 1'b1);
        drain();

        // A request pulsed during SHIFT is dropped.
        send(2'b00, 3, 32'h0000_00FF, 1'b0);
        i_valid  = 1'b1;
        i_data   = 32'hDEAD_BEEF;
        i_amount = '0;
        check_val("busy_ready", 64'(o_ready), 64'd0);
        @(negedge clk);
        i_valid = 1'b0;
        drain();

        // Random mix.
        for (int k = 0; k < 12; k++) begin
            send(2'($urandom_range(0, 3)), int'($urandom_range(0, W - 1)), $urandom(), 1'($urandom_range(0, 1)));
            if (k % 3 == 2) drain();
        end
        drain();

        // Reset mid-operation aborts silently.
        send(2'b00, 1, 32'hFFFF_FFFF, 1'b0); drain();
        send(2'b01, 10, 32'hF0F0_F0F0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_ready", 64'(o_ready), 64'd1);
        check_val("abort_valid", 64'(o_valid), 64'd0);
        check_val("abort_data", 64'(o_data), 64'd0);
`ifdef SEQ_SHIFT_CARRY_EN
        check_val("abort_carry", 64'(o_carry), 64'd0);
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send(2'b10, 5, 32'h8000_0010, 1'b0); drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Iterative, parametrised shift unit that performs LSL, LSR, ASR or ROR by a variable amount, one bit position per clock. It generalises the single-cycle shifter and serial shift register to arbitrary width, adds a valid/ready start handshake and carry-out, and sits beside the ALU as the shift engine for the multi-cycle datapath. The mode encoding matches the existing shifter's 2-bit op field.

## Interface
- W, 32, data width; power of two, ≥ 4
- SW, $clog2(W), shift-amount width (derived; do not override)
- clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_valid  in  1  start request; sampled only when o_ready=1
- o_ready  out  1  unit can accept a request this cycle
- i_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- i_amount  in  SW  shift distance, 0..W-1
- i_data  in  W  operand
- i_carry_in  in  1  carry returned when i_amount=0 (macro-gated)
- o_valid  out  1  one-cycle result strobe
- o_data  out  W  result; holds last result until the next o_valid
- o_carry  out  1  last bit shifted out (macro-gated)

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- o_ready = (state==IDLE) | (state==DONE). i_valid while o_ready=0 is ignored (no queueing).
- Accept (i_valid & o_ready): latch i_data into the working register, latch i_mode, count ← i_amount. Next state SHIFT if i_amount≠0, else DONE (data unchanged, carry ← i_carry_in).
- SHIFT, per edge: one-bit step, count ← count-1; when count==1 before the edge, next state DONE.
  - LSL: {w[W-2:0],0}, carry ← w[W-1]
  - LSR: {0,w[W-1:1]}, carry ← w[0]
  - ASR: {w[W-1],w[W-1:1]}, carry ← w[0]
  - ROR: {w[0],w[W-1:1]}, carry ← w[0]
- DONE: o_valid=1, o_data/o_carry show the result. Next state SHIFT/DONE if a new request is accepted this cycle, else IDLE.
- o_data/o_carry are registered and update only on entry to DONE.
- Reset values: state IDLE, o_ready 1, o_valid 0, o_data 0, o_carry 0, count 0.
- Reset mid-operation: the operation is aborted, no o_valid is issued, and all outputs take their reset values immediately (asynchronous).

## Timing
- Latency: o_valid is high in cycle N+1 after the accepting edge, where N = i_amount (N=0 gives 1 cycle).
- Throughput: one result per N+1 cycles with back-to-back requests accepted in DONE, with no idle gap.
- o_valid is exactly one cycle wide; there is no output back-pressure.
- Inputs are only sampled at the accepting edge. Changes to inputs during SHIFT have no effect.

## Configuration
- SEQ_SHIFT_CARRY_EN defined: i_carry_in and o_carry ports exist, and carry is tracked as specified.
- Not defined: both ports and the carry register are absent. Data behaviour and timing are identical.

## Structure
- Package seq_shift_pkg holds:
  - mode constants MODE_LSL/LSR/ASR/ROR (2-bit)
  - state encoding ST_IDLE/ST_SHIFT/ST_DONE
- One sub-module, shift_step_1b (combinational, W-parameterised). Takes the working word and mode and returns the next word and the shifted-out bit.
- Top level holds the FSM, counter and output registers.

## Test plan
- Case 1: W=32, LSL, i_data 0x0000_0005, amount 3 → o_valid in cycle 4, o_data 0x0000_0028, o_carry 0.
- Case 2: ASR, 0x8000_0000, amount 31 → o_valid in cycle 32, o_data 0xFFFF_FFFF, o_carry 0.
- Case 3: ROR, 0x0000_0003, amount 1 → cycle 2, o_data 0x8000_0001, o_carry 1. Then LSR 0x8000_0000 by 4 → 0x0800_0000, o_carry 0.
- Case 4: amount 0, LSR, 0x1234_5678, i_carry_in 1 → cycle 1, o_data 0x1234_5678, o_carry 1.
- Case 5: i_valid held high continuously with amounts 2 then 1 → results 3 and 2 cycles apart with no idle gap. A request pulsed during SHIFT is dropped (o_ready 0).
- Case 6: amount 10 started, i_rst_n low at cycle 3 → no o_valid, and immediately o_ready 1, o_data 0, o_carry 0. After release, a fresh request completes normally.
